// File: rtl/key_input_conditioner.sv
// Push-button front end: 2-FF synchroniser, per-key debounce and single-key press pulses.
// Presses that coincide with another press or with another key already held are rejected.
module key_input_conditioner #(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keyRaw,
    output logic [NUM_KEYS-1:0] keyPulse,
    output logic [NUM_KEYS-1:0] keyHeld,
    output logic                keyError
);

    localparam int unsigned CNT_WIDTH = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0]  sync1_q, sync2_q;
    logic [NUM_KEYS-1:0]  stable_q, stable_d;
    logic [CNT_WIDTH-1:0] cnt_q [NUM_KEYS];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_KEYS];
    logic [NUM_KEYS-1:0]  pulse_q, pulse_d;
    logic                 error_q, error_d;

    logic [NUM_KEYS-1:0]  lvl;
    logic [NUM_KEYS-1:0]  accept;
    logic [NUM_KEYS-1:0]  press;
    logic                 single;

    always_comb begin
        lvl      = ~sync2_q;
        stable_d = stable_q;
        accept   = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            cnt_d[i] = '0;
            // Any sample matching the stable level restarts the count.
            if (lvl[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    accept[i]   = 1'b1;
                    stable_d[i] = lvl[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                end
            end
        end
        press = accept & lvl;
        // The pressing key's own stable bit is still 0, so any set bit belongs to another key.
        single  = $onehot(press) && (stable_q == '0);
        pulse_d = single ? press : '0;
        error_d = (|press) && !single;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            stable_q <= '0;
            pulse_q  <= '0;
            error_q  <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= keyRaw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            error_q  <= error_d;
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign keyPulse = pulse_q;
    assign keyHeld  = stable_q;
    assign keyError = error_q;

endmodule

// File: tb/tb_key_input_conditioner.sv
// Bench for key_input_conditioner: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a sliding-window debounce model.
module tb_key_input_conditioner;

    localparam int unsigned NK = 4;
    localparam int unsigned D  = 4;

    logic          clock;
    logic          reset;
    logic [NK-1:0] keyRaw;
    logic [NK-1:0] keyPulse;
    logic [NK-1:0] keyHeld;
    logic          keyError;

    int checks = 0;
    int errors = 0;

    key_input_conditioner #(
        .NUM_KEYS       (NK),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .keyRaw  (keyRaw),
        .keyPulse(keyPulse),
        .keyHeld (keyHeld),
        .keyError(keyError)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a level is accepted once the last D synchronised samples (since reset) all
    // disagree with the current debounced level.
    logic [NK-1:0] m_s1, m_s2, m_stable, m_pulse;
    logic          m_err;
    logic [D-1:0]  m_win [NK];
    int            m_valid [NK];
    bit            armed = 0;

    always @(posedge clock) begin
        logic [NK-1:0] lv, pr, nst;
        int n;
        if (reset) begin
            armed    = 1;
            m_s1     = '1;
            m_s2     = '1;
            m_stable = '0;
            m_pulse  = '0;
            m_err    = 1'b0;
            for (int k = 0; k < NK; k++) begin
                m_win[k]   = '0;
                m_valid[k] = 0;
            end
        end else begin
            lv  = ~m_s2;
            pr  = '0;
            nst = m_stable;
            for (int k = 0; k < NK; k++) begin
                m_win[k] = {m_win[k][D-2:0], lv[k]};
                if (m_valid[k] < D) m_valid[k]++;
                if (m_valid[k] >= D && m_win[k] == {D{~m_stable[k]}}) begin
                    nst[k] = lv[k];
                    if (lv[k]) pr[k] = 1'b1;
                end
            end
            n = $countones(pr);
            m_pulse  = (n == 1 && m_stable == '0) ? pr : '0;
            m_err    = (n >= 1) && !(n == 1 && m_stable == '0);
            m_stable = nst;
            m_s2     = m_s1;
            m_s1     = keyRaw;
        end
    end

    always @(negedge clock) begin
        if (armed) begin
            check("model_pulse", 32'(keyPulse), 32'(m_pulse));
            check("model_held", 32'(keyHeld), 32'(m_stable));
            check("model_error", 32'(keyError), 32'(m_err));
        end
    end

    bit            seq_mon = 0;
    logic [NK-1:0] pulses [$];

    always @(negedge clock) begin
        if (seq_mon && keyPulse != '0) pulses.push_back(keyPulse);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        reset  = 1'b1;
        keyRaw = '1;
        tick(2);
        reset = 1'b0;

        // 1: idle
        tick(20);
        check("idle_held", 32'(keyHeld), 32'h0);
        check("idle_pulse", 32'(keyPulse), 32'h0);
        check("idle_error", 32'(keyError), 32'h0);

        // 2: single press, pulse after edge N+5, then release
        keyRaw = 4'hE;
        tick(5);
        check("press0_before", 32'(keyHeld), 32'h0);
        tick(1);
        check("press0_pulse", 32'(keyPulse), 32'h1);
        check("press0_held", 32'(keyHeld), 32'h1);
        tick(1);
        check("press0_pulse_end", 32'(keyPulse), 32'h0);
        keyRaw = 4'hF;
        tick(6);
        check("release0_held", 32'(keyHeld), 32'h0);
        tick(4);

        // 3: bounce never reaching the threshold, then a clean hold
        keyRaw = 4'hD; tick(3);
        keyRaw = 4'hF; tick(1);
        keyRaw = 4'hD; tick(3);
        keyRaw = 4'hF; tick(8);
        check("bounce_held", 32'(keyHeld), 32'h0);
        keyRaw = 4'hD;
        tick(6);
        check("bounce_then_pulse", 32'(keyPulse), 32'h2);
        keyRaw = 4'hF;
        tick(8);

        // 4: simultaneous press, then press while another is held
        keyRaw = 4'hA;
        tick(6);
        check("multi_error", 32'(keyError), 32'h1);
        check("multi_pulse", 32'(keyPulse), 32'h0);
        check("multi_held", 32'(keyHeld), 32'h5);
        tick(1);
        check("multi_error_end", 32'(keyError), 32'h0);
        keyRaw = 4'h6;
        tick(6);
        check("held_other_error", 32'(keyError), 32'h1);
        check("held_other_pulse", 32'(keyPulse), 32'h0);
        check("held_other_held", 32'(keyHeld), 32'h9);
        keyRaw = 4'hF;
        tick(8);

        // 5: reset mid-debounce with key 2 held through it
        keyRaw = 4'hB;
        tick(4);
        reset = 1'b1;
        tick(1);
        check("rst_held", 32'(keyHeld), 32'h0);
        check("rst_pulse", 32'(keyPulse), 32'h0);
        tick(1);
        reset = 1'b0;
        tick(5);
        check("rst_no_early", 32'(keyPulse), 32'h0);
        tick(1);
        check("rst_then_pulse", 32'(keyPulse), 32'h4);
        keyRaw = 4'hF;
        tick(8);

        // 6: sequential presses
        seq_mon = 1;
        for (int k = 0; k < NK; k++) begin
            keyRaw = ~(NK'(1) << k);
            tick(8);
            keyRaw = 4'hF;
            tick(8);
        end
        seq_mon = 0;
        check("seq_count", 32'(pulses.size()), 32'd4);
        for (int k = 0; k < NK; k++) begin
            if (k < pulses.size()) check("seq_value", 32'(pulses[k]), 32'(1 << k));
        end

        // Randomized phase
        for (int seg = 0; seg < 300; seg++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5)      keyRaw = ~(NK'(1) << $urandom_range(0, NK - 1));
            else if (r < 7) keyRaw = '1;
            else if (r < 8) keyRaw = NK'($urandom);
            else            keyRaw = keyRaw ^ (NK'(1) << $urandom_range(0, NK - 1));
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                tick(1);
                reset = 1'b0;
            end
            tick($urandom_range(1, 9));
        end
        keyRaw = '1;
        tick(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
